// File: rtl/npu_conv_pkg.sv
// +----------------------------------------------------------------------------+
// | npu_conv_pkg : shared constants, state type and helpers of the conv engine |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package npu_conv_pkg;

    localparam logic [2:0] SEL_DATA   = 3'b001;
    localparam logic [2:0] SEL_WEIGHT = 3'b010;
    localparam logic [2:0] SEL_RESULT = 3'b011;
    localparam logic [2:0] SEL_CTRL   = 3'b100;

    localparam int CTRL_CLR_BIT  = 0;
    localparam int CTRL_RELU_BIT = 1;
    localparam int CTRL_WPTR_BIT = 2;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_RELU_BIT  = 3;
    localparam int STAT_OVF_BIT   = 4;
    localparam int STAT_UDF_BIT   = 5;
    localparam int STAT_CNT_LSB   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        POST = 2'd2
    } state_e;

    function automatic int calc_n_steps(input int k_h, input int k_w, input int num_pe);
        return (k_h * k_w + num_pe - 1) / num_pe;
    endfunction

endpackage

`default_nettype wire

// File: rtl/npu_result_fifo.sv
// +----------------------------------------------------------------------------+
// | npu_result_fifo : synchronous result FIFO with clear, count, full, empty   |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module npu_result_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop frees the slot the same-cycle push lands in, so full+pop may push.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/npu_conv_engine.sv
// +----------------------------------------------------------------------------+
// | npu_conv_engine : bus-mapped K_H x K_W sliding-window convolution MAC      |
// | Option          : NPU_CONV_ENGINE_RELU_EN enables the ReLU stage           |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module npu_conv_engine #(
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int IMG_W      = 15,
    parameter int NUM_PE     = 4,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        wea,
    input  logic [15:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta
);

    import npu_conv_pkg::*;

    localparam int C_NK      = K_H * K_W;
    localparam int C_N_STEPS = calc_n_steps(K_H, K_W, NUM_PE);
    localparam int C_STEP_W  = $clog2(C_N_STEPS + 1);
    localparam int C_WP_W    = $clog2(C_NK + 4);
    localparam int C_COL_W   = $clog2(IMG_W + 1);
    localparam int C_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [ACC_W-1:0] C_SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [7:0]               r_win [K_H][K_W];
    logic [7:0]               w_shift [K_H][K_W];
    logic [7:0]               r_pix [C_NK];
    logic signed [7:0]        r_wgt [C_NK];
    logic [C_WP_W-1:0]        r_wptr;
    logic [C_COL_W-1:0]       r_col;
    logic [C_STEP_W-1:0]      r_step;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_step_sum;
    logic signed [ACC_W-1:0]  w_post_val;
    logic signed [8:0]        w_px;
    logic signed [16:0]       w_prod;
    logic [OUT_W-1:0]         w_result;
    logic                     r_ovf;
    logic                     r_udf;
    logic [31:0]              r_douta;
    logic [31:0]              w_status;
    logic [2:0]               w_sel;
    logic                     w_data_wr, w_wgt_wr, w_ctrl_wr, w_res_rd, w_rd;
    logic                     w_clr, w_accept, w_trigger, w_push;
    logic [OUT_W-1:0]         w_fifo_data;
    logic [C_CNT_W-1:0]       w_fifo_count;
    logic                     w_fifo_full, w_fifo_empty;
    logic                     w_unused_addr;

    assign w_sel         = addra[2:0];
    assign w_unused_addr = &{1'b0, addra[15:3]};
    assign w_rd          = ena && !wea;
    assign w_data_wr     = ena && wea && (w_sel == SEL_DATA);
    assign w_wgt_wr      = ena && wea && (w_sel == SEL_WEIGHT);
    assign w_ctrl_wr     = ena && wea && (w_sel == SEL_CTRL);
    assign w_res_rd      = w_rd && (w_sel == SEL_RESULT);
    assign w_clr         = w_ctrl_wr && dina[CTRL_CLR_BIT];
    assign w_accept      = w_data_wr && (r_state == IDLE) && !w_fifo_full;
    assign w_trigger     = w_accept && (int'(r_col) >= K_W - 1);
    assign douta         = r_douta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            IDLE: if (w_trigger) w_state_nxt = MAC;
            MAC:  if (int'(r_step) == C_N_STEPS - 1) w_state_nxt = POST;
            POST: begin
                w_push      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_clr) begin
            w_state_nxt = IDLE;
            w_push      = 1'b0;
        end
    end

    // Window after shifting in the bus column; column K_W-1 is the newest.
    always_comb begin
        w_shift = r_win;
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W - 1; c++) w_shift[r][c] = r_win[r][c+1];
            w_shift[r][K_W-1] = dina[8*r +: 8];
        end
    end

    // The MAC works on a snapshot so the live window can be zeroed at row end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            for (int r = 0; r < K_H; r++)
                for (int c = 0; c < K_W; c++) r_win[r][c] <= '0;
            for (int j = 0; j < C_NK; j++) r_pix[j] <= '0;
        end else if (w_clr) begin
            r_col <= '0;
            for (int r = 0; r < K_H; r++)
                for (int c = 0; c < K_W; c++) r_win[r][c] <= '0;
        end else if (w_accept) begin
            if (w_trigger) begin
                for (int r = 0; r < K_H; r++)
                    for (int c = 0; c < K_W; c++) r_pix[r*K_W+c] <= w_shift[r][c];
            end
            if (int'(r_col) == IMG_W - 1) begin
                r_col <= '0;
                for (int r = 0; r < K_H; r++)
                    for (int c = 0; c < K_W; c++) r_win[r][c] <= '0;
            end else begin
                r_col <= r_col + C_COL_W'(1);
                r_win <= w_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            for (int j = 0; j < C_NK; j++) r_wgt[j] <= '0;
        end else begin
            if (w_wgt_wr) begin
                for (int j = 0; j < C_NK; j++)
                    for (int i = 0; i < 4; i++)
                        if (int'(r_wptr) + i == j) r_wgt[j] <= dina[8*i +: 8];
                r_wptr <= (int'(r_wptr) + 4 >= C_NK) ? '0 : C_WP_W'(int'(r_wptr) + 4);
            end
            if (w_ctrl_wr && dina[CTRL_WPTR_BIT]) r_wptr <= '0;
        end
    end

    // Lane p of step s handles weight index s*NUM_PE+p.
    always_comb begin
        w_step_sum = '0;
        w_px       = '0;
        w_prod     = '0;
        for (int j = 0; j < C_NK; j++) begin
            if (j / NUM_PE == int'(r_step)) begin
                w_px       = {1'b0, r_pix[j]};
                w_prod     = w_px * r_wgt[j];
                w_step_sum = w_step_sum + ACC_W'(w_prod);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= '0;
            r_acc  <= '0;
        end else if (w_trigger) begin
            r_step <= '0;
            r_acc  <= '0;
        end else if (r_state == MAC) begin
            r_step <= r_step + C_STEP_W'(1);
            r_acc  <= r_acc + w_step_sum;
        end
    end

`ifdef NPU_CONV_ENGINE_RELU_EN
    logic r_relu_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_relu_en <= 1'b0;
        else if (w_ctrl_wr) r_relu_en <= dina[CTRL_RELU_BIT];
    end
`endif

    always_comb begin
        w_post_val = r_acc;
`ifdef NPU_CONV_ENGINE_RELU_EN
        if (r_relu_en && r_acc[ACC_W-1]) w_post_val = '0;
`endif
        w_result = w_post_val[OUT_W-1:0];
        if (w_post_val > C_SAT_MAX)      w_result = C_SAT_MAX[OUT_W-1:0];
        else if (w_post_val < C_SAT_MIN) w_result = C_SAT_MIN[OUT_W-1:0];
    end

    always_comb begin
        w_status                      = '0;
        w_status[STAT_CNT_LSB +: 8]   = 8'(w_fifo_count);
        w_status[STAT_UDF_BIT]        = r_udf;
        w_status[STAT_OVF_BIT]        = r_ovf;
        w_status[STAT_BUSY_BIT]       = (r_state != IDLE);
        w_status[STAT_FULL_BIT]       = w_fifo_full;
        w_status[STAT_EMPTY_BIT]      = w_fifo_empty;
`ifdef NPU_CONV_ENGINE_RELU_EN
        w_status[STAT_RELU_BIT]       = r_relu_en;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_douta <= '0;
        end else begin
            if (w_clr) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_data_wr && !w_accept)  r_ovf <= 1'b1;
                if (w_res_rd && w_fifo_empty) r_udf <= 1'b1;
            end
            if (w_rd) begin
                case (w_sel)
                    SEL_RESULT: r_douta <= w_fifo_empty ? '0 : 32'(signed'(w_fifo_data));
                    SEL_CTRL:   r_douta <= w_status;
                    default:    r_douta <= '0;
                endcase
            end
        end
    end

    npu_result_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clr),
        .push      (w_push),
        .push_data (w_result),
        .pop       (w_res_rd),
        .pop_data  (w_fifo_data),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_npu_conv_engine.sv
// +----------------------------------------------------------------------------+
// | tb_npu_conv_engine : directed self-checking bench for npu_conv_engine      |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_npu_conv_engine;

    import npu_conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    npu_conv_engine #(
        .K_H        (3),
        .K_W        (3),
        .IMG_W      (5),
        .NUM_PE     (4),
        .ACC_W      (24),
        .OUT_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] sel, input logic [31:0] data);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1; addra = {13'd0, sel}; dina = data;
        @(posedge clk);
        #1;
        ena = 1'b0; wea = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] sel, input string tag, input logic [31:0] exp);
        @(negedge clk);
        ena = 1'b1; wea = 1'b0; addra = {13'd0, sel};
        @(posedge clk);
        #1;
        ena = 1'b0;
        check(tag, douta, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prep(input logic [31:0] ctrl, input logic [31:0] wword);
        bus_wr(SEL_CTRL, ctrl);
        repeat (3) bus_wr(SEL_WEIGHT, wword);
    endtask

    task automatic push_col(input logic [31:0] col);
        bus_wr(SEL_DATA, col);
        cycles(6);
    endtask

    task automatic run3(input logic [31:0] col);
        repeat (3) push_col(col);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_douta", douta, 32'h0);
        rd_chk(SEL_CTRL, "reset_status", 32'h0000_0001);

        // Weights all 1, three {1,2,3} columns: result 18 at E+4.
        prep(32'h5, 32'h0101_0101);
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_DATA, 32'h0003_0201);
        rd_chk(SEL_CTRL, "busy_e1", 32'h0000_0005);
        rd_chk(SEL_CTRL, "busy_e2", 32'h0000_0005);
        rd_chk(SEL_CTRL, "busy_e3", 32'h0000_0005);
        rd_chk(SEL_CTRL, "post_e4", 32'h0000_0005);
        rd_chk(SEL_CTRL, "done_e5", 32'h0000_0100);
        rd_chk(SEL_RESULT, "sum_ones", 32'd18);
        rd_chk(SEL_CTRL, "empty_after_pop", 32'h0000_0001);

        prep(32'h5, 32'hFFFF_FFFF);
        run3(32'h0003_0201);
        rd_chk(SEL_RESULT, "neg_linear", 32'hFFFF_FFEE);
        bus_wr(SEL_CTRL, 32'h3);
        run3(32'h0003_0201);
`ifdef NPU_CONV_ENGINE_RELU_EN
        rd_chk(SEL_RESULT, "neg_relu", 32'h0);
        rd_chk(SEL_CTRL, "relu_status", 32'h0000_0009);
`else
        rd_chk(SEL_RESULT, "neg_relu", 32'hFFFF_FFEE);
        rd_chk(SEL_CTRL, "relu_status", 32'h0000_0001);
`endif

        prep(32'h5, 32'h7F7F_7F7F);
        run3(32'h00FF_FFFF);
        rd_chk(SEL_RESULT, "sat_pos", 32'h0000_7FFF);
        prep(32'h5, 32'h8080_8080);
        run3(32'h00FF_FFFF);
        rd_chk(SEL_RESULT, "sat_neg", 32'hFFFF_8000);

        // Row of IMG_W=5, then the first two columns of the next row.
        prep(32'h5, 32'h0101_0101);
        for (int k = 1; k <= 5; k++) push_col({8'd0, 8'(k), 8'(k), 8'(k)});
        rd_chk(SEL_CTRL, "row_three", 32'h0000_0300);
        push_col(32'h0006_0606);
        push_col(32'h0007_0707);
        rd_chk(SEL_CTRL, "row_restart", 32'h0000_0300);
        push_col(32'h0008_0808);
        rd_chk(SEL_CTRL, "fifo_full", 32'h0000_0402);
        bus_wr(SEL_DATA, 32'h0009_0909);
        rd_chk(SEL_CTRL, "ovf_drop", 32'h0000_0412);
        rd_chk(SEL_RESULT, "row_r0", 32'd18);
        push_col(32'h0009_0909);
        rd_chk(SEL_CTRL, "refill", 32'h0000_0412);
        rd_chk(SEL_RESULT, "row_r1", 32'd27);
        rd_chk(SEL_RESULT, "row_r2", 32'd36);
        rd_chk(SEL_RESULT, "next_row", 32'd63);
        rd_chk(SEL_RESULT, "after_drop", 32'd72);
        rd_chk(SEL_CTRL, "drained", 32'h0000_0011);

        // Soft clear while MAC is running.
        bus_wr(SEL_CTRL, 32'h1);
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_CTRL, 32'h1);
        rd_chk(SEL_CTRL, "clr_abort", 32'h0000_0001);
        cycles(6);
        rd_chk(SEL_CTRL, "no_push", 32'h0000_0001);
        rd_chk(SEL_RESULT, "udf_read", 32'h0);
        rd_chk(SEL_CTRL, "udf_flag", 32'h0000_0021);

        // Asynchronous reset mid-compute.
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_DATA, 32'h0003_0201);
        bus_wr(SEL_DATA, 32'h0003_0201);
        #2;
        rst = 1'b1;
        #1;
        check("async_douta", douta, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk(SEL_CTRL, "post_reset", 32'h0000_0001);
        cycles(6);
        rd_chk(SEL_CTRL, "reset_no_push", 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/npu_conv_engine.md
# npu_conv_engine

Parametrised convolution MAC engine and successor to the fixed 3x3 NPU convolution datapath. The host streams input columns into a K_H x K_W sliding window over a host-mapped bus and loads the signed weights. Each accepted column triggers a multi-cycle dot product on NUM_PE multiplier lanes, with optional ReLU and saturation. Results queue in an output FIFO that the host pops.

## Interface
- K_H, 3: window rows (1..4, one byte lane per row)
- K_W, 3: window columns
- IMG_W, 15: input row length in columns; window restarts at row end
- NUM_PE, 4: parallel multiply lanes
- ACC_W, 24: signed accumulator width
- OUT_W, 16: signed result width after saturation (OUT_W ≤ 32)
- FIFO_DEPTH, 8: result FIFO entries (power of 2)
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- ena  in  1  bus enable
- wea  in  1  write when 1, read when 0 (only with ena)
- addra  in  16  address; addra[2:0] is the register select
- dina  in  32  write data
- douta  out  32  read data, registered

## Operation
- sel 3'b001 W DATA: dina[8i+7:8i] is the pixel for row i (unsigned 8-bit). The column shifts into the window. It is accepted only if state is IDLE and fifo_count < FIFO_DEPTH. Otherwise the write is dropped and sticky `ovf` is set.
- sel 3'b010 W WEIGHT: four signed 8-bit weights go to indices wptr..wptr+3, byte 0 first. wptr advances by 4 and wraps to 0 at or past K_H*K_W. Indices ≥ K_H*K_W are ignored. Weight index order is r*K_W+c, with c=0 the oldest column.
- sel 3'b011 R RESULT: pops the FIFO and returns the result sign-extended to 32 bits. A read while empty returns 0 and sets `udf`.
- sel 3'b100 W CTRL:
  - bit0 soft clear: window, column counter, FIFO, ovf, udf; aborts any compute.
  - bit1 relu_en.
  - bit2 resets wptr to 0.
- sel 3'b100 R STATUS: {fifo_count[7:0] at [15:8], udf[5], ovf[4], relu_en[3], busy[2], full[1], empty[0]}.
- Other sel values: writes ignored, reads return 0.
- Column counter col:
  - Increments per accepted column.
  - Compute triggers on every accepted column with col ≥ K_W−1 within the current row.
  - At col = IMG_W−1 the column is processed, then col wraps to 0 and the window is invalidated (zeroed).
  - Each row yields IMG_W−K_W+1 results.
- FSM:
  - IDLE → MAC on a triggering column.
  - MAC runs N_STEPS = ceil(K_H*K_W/NUM_PE) cycles. Each cycle computes NUM_PE products of pixel × weight into the signed ACC_W accumulator. Unused lanes contribute 0.
  - MAC → POST.
  - POST: apply ReLU if enabled (negative → 0), saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1], push to FIFO → IDLE.
- Simultaneous pop and push: both take effect and the count is unchanged.
- Weight writes during MAC are allowed; the result then uses a mix of old and new weights (the software forbids this).

## Timing
- Reset values: douta=0, state IDLE, window/weights/wptr/col=0, FIFO empty, relu_en=0, ovf=udf=0.
- douta is valid on the cycle after the read edge.
- Column accepted at edge E:
  - busy=1 from E+1.
  - MAC edges E+1..E+N_STEPS.
  - POST pushes at edge E+N_STEPS+1.
  - busy=0 and the count updates after that edge.
  - Latency is N_STEPS+1 cycles.
- Soft clear wins over a same-cycle push.
- Asynchronous rst mid-compute discards everything immediately.

## Configuration
- NPU_CONV_ENGINE_RELU_EN
  - Defined: CTRL bit1 controls ReLU in POST, and STATUS bit3 reflects it.
  - Undefined: the ReLU logic is absent, bit1 is ignored, STATUS bit3 reads 0, and results are always linear and saturated.

## Structure
- npu_conv_pkg holds:
  - The sel constants (SEL_DATA, SEL_WEIGHT, SEL_RESULT, SEL_CTRL).
  - CTRL and STATUS bit positions.
  - The state_e enum (IDLE, MAC, POST).
  - The function computing N_STEPS.
- Sub-module npu_result_fifo: synchronous FIFO, OUT_W wide, FIFO_DEPTH deep, with push, pop, clear, count, full and empty.

## Test plan
- K=3x3, NUM_PE=4, all weights 1; write columns {1,2,3} ×3 → one result, 18, pushed 4 cycles after the third write; RESULT read returns 32'd18.
- All weights −1, same columns: relu_en=0 → 0xFFFFFFEE (−18); relu_en=1 (macro defined) → 0.
- Weights 127, pixels 255, OUT_W=16 → sum 291465 saturates to 32767; with weights −128 → −32768.
- IMG_W=5: 5 column writes → 3 results. The 6th and 7th columns give no result; the 8th gives one, computed from columns 6..8 only.
- FIFO_DEPTH=4: fill to 4 results, then a further data write → dropped, ovf=1, count stays 4. Pop once, rewrite the column → accepted.
- Soft clear during MAC → no push, empty=1, busy=0 next cycle. A pop while empty → 0 and udf=1.
